// File: rtl/io_bridge_if.sv
// CPU-side request/response bus of the io_bridge.
interface io_bridge_if;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_we;
    logic        cpu_resp_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;

    modport slave (
        input  cpu_req_valid, cpu_addr, cpu_wdata, cpu_size, cpu_we,
        output cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_fault
    );

    modport master (
        output cpu_req_valid, cpu_addr, cpu_wdata, cpu_size, cpu_we,
        input  cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_fault
    );
endinterface

// File: rtl/io_bridge.sv
// Single-outstanding CPU to output-device bridge with window/alignment checking.
// Fault reporting is enabled by defining IO_BRIDGE_FAULT_EN; otherwise addresses are aligned silently.
module io_bridge #(
    parameter logic [31:0] IO_BASE = 32'hF000_0000,
    parameter logic [31:0] IO_SPAN = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    io_bridge_if.slave  cpu,
    output logic [31:0] output_address,
    output logic [31:0] output_in,
    output logic [1:0]  output_size,
    output logic        output_write_enable,
    input  logic [31:0] output_out
);

    // state | meaning
    // IDLE  | ready for a new request
    // ISSUE | captured access presented to the device for one cycle
    // RESP  | one-cycle completion pulse towards the CPU
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        bypass_q, bypass_d;

    logic [32:0] addr_ext, win_lo, win_hi;
    logic        in_win;
    logic        reject;
    logic [1:0]  size_norm;
    logic [31:0] addr_norm;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // 33-bit window bounds so a window ending exactly at 2^32 is representable
    assign addr_ext = {1'b0, cpu.cpu_addr};
    assign win_lo   = {1'b0, IO_BASE};
    assign win_hi   = {1'b0, IO_BASE} + {1'b0, IO_SPAN};
    assign in_win   = (addr_ext >= win_lo) && (addr_ext < win_hi);

`ifdef IO_BRIDGE_FAULT_EN
    logic misalign;
    assign misalign  = (cpu.cpu_size == 2'd3)
                     || ((cpu.cpu_size == 2'd1) && cpu.cpu_addr[0])
                     || ((cpu.cpu_size == 2'd2) && (cpu.cpu_addr[1:0] != 2'b00));
    assign reject    = !in_win || misalign;
    assign size_norm = cpu.cpu_size;
    assign addr_norm = cpu.cpu_addr;
`else
    assign reject    = !in_win;
    assign size_norm = (cpu.cpu_size == 2'd3) ? 2'd2 : cpu.cpu_size;
    always_comb begin
        addr_norm = cpu.cpu_addr;
        case (size_norm)
            2'd0:    addr_norm[1:0] = cpu.cpu_addr[1:0];
            2'd1:    addr_norm[1:0] = {cpu.cpu_addr[1], 1'b0};
            default: addr_norm[1:0] = 2'b00;
        endcase
    end
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        we_d     = we_q;
        bypass_d = bypass_q;
        case (state_q)
            IDLE: begin
                if (cpu.cpu_req_valid) begin
                    addr_d   = addr_norm;
                    wdata_d  = cpu.cpu_wdata;
                    size_d   = size_norm;
                    we_d     = cpu.cpu_we;
                    bypass_d = reject;
                    state_d  = reject ? RESP : ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            we_q     <= we_d;
            bypass_q <= bypass_d;
        end
    end

    assign shifted = output_out >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_data = {24'h0, shifted[7:0]};
            2'd1:    load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Outputs are masked during reset so an aborted access never strobes the device
    always_comb begin
        cpu.cpu_req_ready   = (state_q == IDLE) || rst;
        cpu.cpu_resp_valid  = 1'b0;
        cpu.cpu_fault       = 1'b0;
        cpu.cpu_rdata       = '0;
        output_address      = '0;
        output_in           = '0;
        output_size         = '0;
        output_write_enable = 1'b0;
        if (!rst && (state_q == ISSUE)) begin
            output_address      = addr_q - IO_BASE;
            output_in           = wdata_q;
            output_size         = size_q;
            output_write_enable = we_q;
        end
        if (!rst && (state_q == RESP)) begin
            cpu.cpu_resp_valid = 1'b1;
`ifdef IO_BRIDGE_FAULT_EN
            cpu.cpu_fault      = bypass_q;
`endif
            cpu.cpu_rdata      = (bypass_q || we_q) ? 32'h0 : load_data;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed vector table, reset abort, randomized model check.
module tb_io_bridge;

    localparam logic [31:0] IO_BASE = 32'hF000_0000;
    localparam logic [31:0] IO_SPAN = 32'h0000_0100;
`ifdef IO_BRIDGE_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_bridge_if bus();

    logic [31:0] output_address, output_in, output_out;
    logic [1:0]  output_size;
    logic        output_write_enable;

    io_bridge #(.IO_BASE(IO_BASE), .IO_SPAN(IO_SPAN)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu                 (bus),
        .output_address      (output_address),
        .output_in           (output_in),
        .output_size         (output_size),
        .output_write_enable (output_write_enable),
        .output_out          (output_out)
    );

    // Output device: a single led register, read back one cycle after being addressed
    logic [31:0] led   = '0;
    logic [31:0] dev_q = '0;
    always @(posedge clk) begin
        if (output_write_enable) led <= output_in;
        dev_q <= output_write_enable ? output_in : led;
    end
    assign output_out = dev_q;

    int vec  = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic        f;
        logic [31:0] oaddr;
        logic [1:0]  osz;
        logic [31:0] rd;
        logic [31:0] led_after;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] sz, logic [31:0] a, logic [31:0] wd,
                                int lat, logic f, logic [31:0] oa, logic [1:0] osz,
                                logic [31:0] rd, logic [31:0] led_after);
        vec_t v;
        v.we = we; v.sz = sz; v.addr = a; v.wd = wd; v.lat = lat; v.f = f;
        v.oaddr = oa; v.osz = osz; v.rd = rd; v.led_after = led_after;
        return v;
    endfunction

    // Reference: derive the access outcome from the window/alignment rules directly
    function automatic vec_t model(logic we, logic [1:0] sz, logic [31:0] a, logic [31:0] wd,
                                   logic [31:0] led_now);
        vec_t        v;
        logic [63:0] ax, lo, hi;
        bit          in_win, bad;
        logic [1:0]  esz;
        logic [31:0] ea, mask;
        ax = {32'h0, a};
        lo = {32'h0, IO_BASE};
        hi = {32'h0, IO_BASE} + {32'h0, IO_SPAN};
        in_win = (ax >= lo) && (ax < hi);
        esz = (sz == 2'd3) ? 2'd2 : sz;
        if (FE) begin
            bad = !in_win || (sz == 2'd3) || ((a & ((32'd1 << esz) - 1)) != 0);
            ea  = a;
        end else begin
            bad = !in_win;
            ea  = a & ~((32'd1 << esz) - 1);
        end
        mask = (esz == 2'd0) ? 32'hFF : (esz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        v.we = we; v.sz = sz; v.addr = a; v.wd = wd;
        v.lat       = bad ? 1 : 2;
        v.f         = FE && bad;
        v.oaddr     = bad ? 32'h0 : ea - IO_BASE;
        v.osz       = esz;
        v.rd        = (bad || we) ? 32'h0 : ((led_now >> (8 * ea[1:0])) & mask);
        v.led_after = (!bad && we) ? wd : led_now;
        return v;
    endfunction

    // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
    // While busy, valid stays high with a junk store so any illegal accept is visible on led.
    task automatic txn(input vec_t v);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_we        = v.we;
        bus.cpu_size      = v.sz;
        bus.cpu_addr      = v.addr;
        bus.cpu_wdata     = v.wd;
        chk("ready_idle", bus.cpu_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cpu_we    = 1'b1;
        bus.cpu_size  = 2'd2;
        bus.cpu_addr  = IO_BASE + ($urandom & 32'hFC);
        bus.cpu_wdata = $urandom;
        chk("ready_busy", bus.cpu_req_ready, 0);
        if (v.lat == 2) begin
            chk("issue_we",   output_write_enable, v.we);
            chk("issue_addr", output_address, v.oaddr);
            chk("issue_in",   output_in, v.wd);
            chk("issue_size", output_size, v.osz);
            chk("issue_rv",   bus.cpu_resp_valid, 0);
            @(negedge clk);
        end else begin
            chk("bypass_we",   output_write_enable, 0);
            chk("bypass_addr", output_address, 0);
        end
        chk("resp_valid", bus.cpu_resp_valid, 1);
        chk("resp_fault", bus.cpu_fault, v.f);
        chk("resp_rdata", bus.cpu_rdata, v.rd);
        chk("resp_we",    output_write_enable, 0);
        @(negedge clk);
        chk("idle_rv",    bus.cpu_resp_valid, 0);
        chk("idle_rdata", bus.cpu_rdata, 0);
        chk("led",        led, v.led_after);
    endtask

    vec_t        tbl[15];
    vec_t        rv;
    logic [31:0] led_m;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cpu_req_valid = 1'b0;
        bus.cpu_we        = 1'b0;
        bus.cpu_size      = 2'd0;
        bus.cpu_addr      = '0;
        bus.cpu_wdata     = '0;

        tbl[0]  = mk(1, 0, IO_BASE,         32'h0000_00A5, 2, 0, 32'h0,  0, 32'h0, 32'h0000_00A5);
        tbl[1]  = mk(0, 2, IO_BASE,         32'h0,         2, 0, 32'h0,  2, 32'hA5, 32'h0000_00A5);
        tbl[2]  = mk(0, 0, IO_BASE + 1,     32'h0,         2, 0, 32'h1,  0, 32'h0, 32'h0000_00A5);
        tbl[3]  = mk(0, 1, IO_BASE,         32'h0,         2, 0, 32'h0,  1, 32'hA5, 32'h0000_00A5);
        tbl[4]  = mk(1, 2, 32'h0000_1000,   32'hDEAD_BEEF, 1, FE, 32'h0, 2, 32'h0, 32'h0000_00A5);
        tbl[5]  = mk(0, 1, IO_BASE + 3,     32'h0,         FE ? 1 : 2, FE, FE ? 32'h0 : 32'h2, 1, 32'h0, 32'h0000_00A5);
        tbl[6]  = mk(1, 1, IO_BASE + 32'h10, 32'h0000_1234, 2, 0, 32'h10, 1, 32'h0, 32'h0000_1234);
        tbl[7]  = mk(0, 0, IO_BASE + 32'h11, 32'h0,        2, 0, 32'h11, 0, 32'h12, 32'h0000_1234);
        tbl[8]  = mk(0, 2, IO_BASE + 32'hFC, 32'h0,        2, 0, 32'hFC, 2, 32'h1234, 32'h0000_1234);
        tbl[9]  = mk(0, 2, IO_BASE + 32'h100, 32'h0,       1, FE, 32'h0, 2, 32'h0, 32'h0000_1234);
        tbl[10] = mk(0, 0, IO_BASE - 1,     32'h0,         1, FE, 32'h0, 0, 32'h0, 32'h0000_1234);
        tbl[11] = mk(0, 3, IO_BASE + 4,     32'h0,         FE ? 1 : 2, FE, FE ? 32'h0 : 32'h4, 2, FE ? 32'h0 : 32'h1234, 32'h0000_1234);
        tbl[12] = mk(0, 2, IO_BASE + 2,     32'h0,         FE ? 1 : 2, FE, 32'h0, 2, FE ? 32'h0 : 32'h1234, 32'h0000_1234);
        tbl[13] = mk(1, 2, IO_BASE + 32'h20, 32'hCAFE_F00D, 2, 0, 32'h20, 2, 32'h0, 32'hCAFE_F00D);
        tbl[14] = mk(0, 1, IO_BASE + 32'h22, 32'h0,        2, 0, 32'h22, 1, 32'hCAFE, 32'hCAFE_F00D);

        repeat (2) @(negedge clk);
        chk("rst_ready", bus.cpu_req_ready, 1);
        chk("rst_rv",    bus.cpu_resp_valid, 0);
        chk("rst_fault", bus.cpu_fault, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_we",    output_write_enable, 0);
        chk("rst_addr",  output_address, 0);
        chk("rst_in",    output_in, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) txn(tbl[i]);

        // Reset during ISSUE of a store: access must be abandoned
        bus.cpu_req_valid = 1'b1;
        bus.cpu_we        = 1'b1;
        bus.cpu_size      = 2'd2;
        bus.cpu_addr      = IO_BASE + 32'h30;
        bus.cpu_wdata     = 32'h0000_003C;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        chk("abort_issue_we", output_write_enable, 1);
        rst = 1'b1;
        #1;
        chk("abort_gated_we", output_write_enable, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", bus.cpu_req_ready, 1);
        chk("abort_rv",    bus.cpu_resp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet_rv", bus.cpu_resp_valid, 0);
        end
        chk("abort_led", led, 32'hCAFE_F00D);
        txn(mk(0, 2, IO_BASE + 32'h30, 32'h0, 2, 0, 32'h30, 2, 32'hCAFE_F00D, 32'hCAFE_F00D));

        led_m = 32'hCAFE_F00D;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int          r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = IO_BASE + $urandom_range(0, IO_SPAN - 1);
            else if (r == 7) a = $urandom;
            else if (r == 8) a = IO_BASE + IO_SPAN + $urandom_range(0, 3);
            else             a = IO_BASE - $urandom_range(1, 4);
            rv = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, led_m);
            led_m = rv.led_after;
            txn(rv);
        end

        bus.cpu_req_valid = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'hF000_0000, base address of the output-device window.
REQ-002 SHALL have parameter IO_SPAN, default 32'h0000_0100, window size in bytes (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_req_valid  input  1  CPU access request.
REQ-006 SHALL have port cpu_req_ready  output  1  bridge can accept a request.
REQ-007 SHALL have port cpu_addr  input  32  byte address.
REQ-008 SHALL have port cpu_wdata  input  32  store data, LSB-aligned.
REQ-009 SHALL have port cpu_size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-010 SHALL have port cpu_we  input  1  1=store, 0=load.
REQ-011 SHALL have port cpu_resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port cpu_rdata  output  32  load data, zero-extended.
REQ-013 SHALL have port cpu_fault  output  1  access faulted; valid with cpu_resp_valid.
REQ-014 SHALL have ports output_address(32), output_in(32), output_size(2), output_write_enable(1) as outputs and output_out(32) as input, connecting to the output device; the device registers output_out one cycle after being addressed.

Function
REQ-015 SHALL implement states IDLE, ISSUE, RESP; cpu_req_ready=1 only in IDLE.
REQ-016 SHALL accept on cpu_req_valid && cpu_req_ready (cycle T), registering addr, wdata, size, we.
REQ-017 SHALL classify an access as faulting if the address is outside [IO_BASE, IO_BASE+IO_SPAN), size==3, half at odd address, or word at address with addr[1:0]!=0.
REQ-018 SHALL, for a non-faulting access, go IDLE->ISSUE at T+1, ISSUE->RESP at T+2, RESP->IDLE at T+3.
REQ-019 SHALL, in ISSUE only, drive output_address=addr-IO_BASE, output_in=wdata, output_size=size, output_write_enable=we; otherwise drive output_address, output_in, output_size, and output_write_enable to 0.
REQ-020 SHALL, in RESP, assert cpu_resp_valid for exactly one cycle with cpu_fault=0; for loads, cpu_rdata = (output_out >> 8*addr[1:0]) masked to 8/16/32 bits per size; for stores, cpu_rdata=0.
REQ-021 SHALL, for a faulting access, go IDLE->RESP at T+1 (skipping ISSUE), with cpu_fault=1, cpu_rdata=0, and no output_write_enable pulse.
REQ-022 SHALL ignore cpu_req_valid while not in IDLE; back-to-back requests are accepted no earlier than the IDLE cycle after RESP.
REQ-023 SHALL keep cpu_resp_valid, cpu_fault, and cpu_rdata at 0 outside RESP.
REQ-024 SHALL compute the window check without overflow (33-bit compare) so that IO_BASE+IO_SPAN=2^32 is legal.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, enter IDLE and clear all captured registers; all outputs SHALL be 0 except cpu_req_ready=1.
REQ-026 SHALL, when rst is asserted during ISSUE or RESP, abort the access: no write strobe after that edge and no cpu_resp_valid.

Configuration
REQ-027 SHALL gate fault detection with macro IO_BRIDGE_FAULT_EN: when defined, REQ-017/REQ-021 apply; when undefined, cpu_fault is tied 0, the low address bits are masked to natural alignment (size 3 treated as word), and out-of-window accesses follow the fault timing (RESP at T+1, rdata 0, no device activity) with cpu_fault=0.

Verification
REQ-028 SHALL test: store byte 0xA5 to IO_BASE -> output_write_enable=1 for one cycle at T+1 with output_address=0 and output_in=0xA5; cpu_resp_valid at T+2; device led=0xA5.
REQ-029 SHALL test: after REQ-028, load word from IO_BASE -> cpu_resp_valid at T+2 with cpu_rdata=0x000000A5 and cpu_fault=0.
REQ-030 SHALL test: with the device returning 0x000000A5, load byte from IO_BASE+1 -> cpu_rdata=0x00000000; load half from IO_BASE -> cpu_rdata=0x000000A5.
REQ-031 SHALL test: store word to 0x0000_1000 (FAULT_EN defined) -> cpu_resp_valid and cpu_fault=1 at T+1, no write strobe, led unchanged; with the macro undefined, cpu_fault=0.
REQ-032 SHALL test: load half from IO_BASE+3 (FAULT_EN defined) -> fault at T+1; with the macro undefined, access goes to output_address=2.
REQ-033 SHALL test: rst pulsed during ISSUE of a store of 0x3C -> no cpu_resp_valid, cpu_req_ready=1 the cycle after reset, led keeps its prior value.
